// File: rtl/tc1_responder.sv
// tc1_responder: SPI responder streaming a 32-bit thermocouple frame to the master
module tc1_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        CS,
  output logic        MISO,
  output logic        miso_oe,
  input  logic [13:0] temperature_termoc,
  input  logic [11:0] temperature_internal,
  input  logic [2:0]  status,
  output logic        frame_active,
  output logic        frame_done,
  output logic [5:0]  bit_cnt
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic sclk_q, cs_q, sclk_fall, cs_fall, cs_rise;
  logic [31:0] sreg, sreg_n, word;
  logic [5:0] cnt_n;
  logic miso_n, act_n, done_n;
  // Flops reset to 0 so a CS held low across reset release never looks like a falling edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_sync <= '0;
      cs_sync <= '0;
      sclk_q <= 1'b0;
      cs_q <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_q <= sclk_sync[SYNC_STAGES-1];
      cs_q <= cs_sync[SYNC_STAGES-1];
    end
  assign sclk_fall = sclk_q & ~sclk_sync[SYNC_STAGES-1];
  assign cs_fall = cs_q & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise = ~cs_q & cs_sync[SYNC_STAGES-1];
  assign word = {temperature_termoc, 1'b0, |status, temperature_internal, 1'b0, status};
  assign miso_oe = frame_active;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      MISO <= 1'b0;
      frame_active <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      bit_cnt <= cnt_n;
      MISO <= miso_n;
      frame_active <= act_n;
      frame_done <= done_n;
    end
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    cnt_n = bit_cnt;
    miso_n = MISO;
    act_n = frame_active;
    done_n = 1'b0;
    case (state)
      IDLE:
        if (cs_fall) begin
          state_n = SHIFT;
          sreg_n = word;
          cnt_n = '0;
          miso_n = word[31];
          act_n = 1'b1;
        end
      default:
        if (cs_rise) begin
          state_n = IDLE;
          miso_n = 1'b0;
          act_n = 1'b0;
          done_n = 1'b1;
        end else if (state == SHIFT && sclk_fall) begin
          sreg_n = {sreg[30:0], 1'b0};
          cnt_n = bit_cnt + 6'd1;
          miso_n = (bit_cnt == 6'd31) ? 1'b0 : sreg[30];
          state_n = (bit_cnt == 6'd31) ? DONE : SHIFT;
        end
    endcase
  end
endmodule

// File: tb/tb_tc1_responder.sv
// tb_tc1_responder: directed SPI master reads against tc1_responder
module tb_tc1_responder;
  logic clk = 1'b0, rst = 1'b1, SCLK = 1'b0, CS = 1'b1;
  logic MISO, miso_oe, frame_active, frame_done;
  logic [5:0] bit_cnt;
  logic [13:0] temperature_termoc = 14'h0190;
  logic [11:0] temperature_internal = 12'h190;
  logic [2:0] status = 3'b000;
  logic [63:0] cap;
  int passed = 0, total = 0, nd;

  tc1_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MISO(MISO), .miso_oe(miso_oe),
    .temperature_termoc(temperature_termoc), .temperature_internal(temperature_internal),
    .status(status), .frame_active(frame_active), .frame_done(frame_done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cs_low();
    @(negedge clk);
    CS = 1'b0;
    cap = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1;
      cap = {cap[62:0], MISO};
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic cs_high();
    CS = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done) nd++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso", MISO, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", bit_cnt, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // nominal read, with load latency probed around the third clk edge
    CS = 1'b0;
    cap = '0;
    repeat (2) @(negedge clk);
    chk("lat_before_load", frame_active, 0);
    @(negedge clk);
    chk("lat_load", frame_active, 1);
    chk("lat_oe", miso_oe, 1);
    chk("load_cnt", bit_cnt, 0);
    repeat (7) @(negedge clk);
    pulses(32);
    chk("nominal_word", cap[31:0], 32'h06401900);
    repeat (5) @(negedge clk);
    chk("nominal_cnt", bit_cnt, 32);
    chk("done_miso", MISO, 0);
    cs_high();
    chk("nominal_done_pulses", nd, 1);
    chk("nominal_oe_off", miso_oe, 0);
    pulses(3);
    chk("idle_sclk_cnt", bit_cnt, 32);
    // fault frame
    status = 3'b001;
    cs_low();
    pulses(32);
    chk("fault_word", cap[31:0], 32'h06411901);
    cs_high();
    status = 3'b000;
    // short read
    cs_low();
    pulses(16);
    chk("short_word", cap[15:0], 16'h0640);
    chk("short_cnt", bit_cnt, 16);
    cs_high();
    chk("short_done_pulses", nd, 1);
    chk("short_miso", MISO, 0);
    chk("short_oe", miso_oe, 0);
    chk("short_active", frame_active, 0);
    // overclock
    cs_low();
    pulses(40);
    chk("over_word", cap[39:8], 32'h06401900);
    chk("over_tail", cap[7:0], 8'h00);
    chk("over_cnt", bit_cnt, 32);
    cs_high();
    // snapshot isolation
    cs_low();
    pulses(5);
    temperature_termoc = 14'h3FFF;
    pulses(27);
    chk("snap_word", cap[31:0], 32'h06401900);
    cs_high();
    cs_low();
    pulses(32);
    chk("snap_next_word", cap[31:0], 32'hFFFC1900);
    cs_high();
    temperature_termoc = 14'h0190;
    // reset mid-frame
    cs_low();
    pulses(10);
    chk("pre_rst_cnt", bit_cnt, 10);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_miso", MISO, 0);
    chk("mid_rst_active", frame_active, 0);
    chk("mid_rst_oe", miso_oe, 0);
    chk("mid_rst_cnt", bit_cnt, 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_done) nd++;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    pulses(4);
    chk("no_load_cs_low_active", frame_active, 0);
    chk("no_load_cs_low_cnt", bit_cnt, 0);
    cs_high();
    chk("no_done_idle_release", nd, 0);
    cs_low();
    chk("reload_cnt", bit_cnt, 0);
    chk("reload_active", frame_active, 1);
    pulses(32);
    chk("reload_word", cap[31:0], 32'h06401900);
    chk("reload_cnt_full", bit_cnt, 32);
    cs_high();
    chk("reload_done_pulses", nd, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
